// File: rtl/univ_shift_reg_pkg.sv
// Shared constants for univ_shift_reg: operation modes and burst sequencer states.
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } seq_state_t;

  // Only shifts and rotates may be repeated by the burst sequencer.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ROR);
  endfunction

endpackage

// File: rtl/usr_datapath.sv
// Combinational next-state of the shift register: computes next q and the bit
// shifted out for one operation; shift_op flags modes that update sout.
module usr_datapath
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q_nxt,
  output logic             sout_nxt,
  output logic             shift_op
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    q_nxt    = q;
    sout_nxt = 1'b0;
    shift_op = 1'b0;
    case (mode)
      MODE_LOAD: q_nxt = d;
      MODE_SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin};
        sout_nxt = q[WIDTH-1];
        shift_op = 1'b1;
      end
      MODE_SHR: begin
        q_nxt    = {sin, q[WIDTH-1:1]};
        sout_nxt = q[0];
        shift_op = 1'b1;
      end
      MODE_ROL: begin
        q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_nxt = q[WIDTH-1];
        shift_op = 1'b1;
      end
      MODE_ROR: begin
        q_nxt    = {q[0], q[WIDTH-1:1]};
        sout_nxt = q[0];
        shift_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, shift/rotate and a burst
// sequencer. Define UNIV_SHIFT_REG_PARITY_EN to add a registered parity output.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 5,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef UNIV_SHIFT_REG_PARITY_EN
  , output logic           parity
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       mode_lat, mode_lat_nxt;
  logic [2:0]       dp_mode;
  logic             busy_nxt, done_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             dp_sout, dp_shift, sout_nxt;

  usr_datapath #(.WIDTH(WIDTH)) u_datapath (
    .mode     (dp_mode),
    .q        (q),
    .d        (d),
    .sin      (sin),
    .q_nxt    (q_nxt),
    .sout_nxt (dp_sout),
    .shift_op (dp_shift)
  );

  // Idle cycles run the live mode; burst cycles replay the latched one and
  // the FIN cycle only retires the burst.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    mode_lat_nxt = mode_lat;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    dp_mode      = MODE_HOLD;
    case (state)
      S_IDLE: begin
        dp_mode = mode;
        if (start && (count != '0) && is_shift_mode(mode)) begin
          mode_lat_nxt = mode;
          cnt_nxt      = count - CNT_ONE;
          busy_nxt     = 1'b1;
          state_nxt    = (count == CNT_ONE) ? S_FIN : S_SHIFT;
        end
      end
      S_SHIFT: begin
        dp_mode = mode_lat;
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = S_FIN;
      end
      S_FIN: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    sout_nxt = dp_shift ? dp_sout : sout;
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mode_lat <= MODE_HOLD;
      q        <= RST_VAL;
      sout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (en) begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mode_lat <= mode_lat_nxt;
      q        <= q_nxt;
      sout     <= sout_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end else begin
      // Frozen cycles must not stretch the done pulse.
      done <= 1'b0;
    end
  end

`ifdef UNIV_SHIFT_REG_PARITY_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset)   parity <= ^RST_VAL;
    else if (en) parity <= ^q_nxt;
  end
`endif

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the board-level enabled D flip-flop register.
- WIDTH-bit register with synchronous reset, clock enable, parallel load, shift left/right, rotate left/right, and a burst sequencer that performs a programmed number of shifts after one start pulse.
- Sits between switch/key inputs and LEDR/HEX outputs in board demos; also reusable as a serialiser.

Parameters:
- WIDTH, 8, register width in bits (legal range 2..32).
- CNT_W, 5, width of burst shift count; maximum burst is 2**CNT_W-1.
- RST_VAL, 0, value loaded into q on reset (WIDTH bits, zero-extended).

Ports:
- CLOCK_50  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous active-high reset.
- en  input  1  clock enable; when 0, all state holds (sequencer included).
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input for shift modes.
- start  input  1  single-cycle pulse; begins a burst in the current mode.
- count  input  CNT_W  burst length, sampled on start.
- q  output  WIDTH  register contents.
- sout  output  1  bit shifted out on the last shift (registered).
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse on burst completion.

Behaviour:
- Reset (reset=1 on a rising edge, regardless of en): q=RST_VAL, sout=0, busy=0, done=0, state=IDLE, internal counter=0. Reset has priority over everything. Reset mid-burst aborts the burst with no done pulse.
- Mode encoding:
  - 0 HOLD
  - 1 LOAD: q<=d
  - 2 SHL: q<={q[W-2:0],sin}, sout<=q[W-1]
  - 3 SHR: q<={sin,q[W-1:1]}, sout<=q[0]
  - 4 ROL: sout<=q[W-1]
  - 5 ROR: sout<=q[0]
  - 6 and 7 behave as HOLD.
- Direct operation (state IDLE, start=0, en=1): the mode operation executes every enabled cycle, with one-cycle latency from inputs to q.
- Sequencer states:
  - IDLE: start=1 & en=1 & count!=0 & mode in 2..5 → latch mode and count, perform the first shift in the same cycle, counter<=count-1, busy<=1. If count-1==0, go to FIN; otherwise go to SHIFT.
  - IDLE: start with count==0 or a non-shift mode → treated as direct operation, no busy, no done.
  - SHIFT: each enabled cycle performs the latched operation and decrements the counter. When counter reaches 1 the final shift occurs and the state goes to FIN.
  - FIN: busy<=0, done<=1 for exactly one cycle, then IDLE.
- During a burst the mode and count inputs are ignored; sin is still sampled live each shift cycle. start during SHIFT/FIN is ignored.
- en=0 during a burst freezes the counter, q and state. done never asserts while en=0; it asserts on the first enabled FIN cycle.
- A burst of N shifts takes N cycles with busy high. done follows one cycle after the last shift. With count=1: busy for 1 cycle, done the next cycle.
- Rotations are modulo WIDTH; a burst of WIDTH rotations restores q.

Optional Feature:
- Macro: UNIV_SHIFT_REG_PARITY_EN.
- Defined: adds output parity (1 bit) = registered even-parity XOR of q, updated in the same cycle as q; reset value = XOR of RST_VAL.
- Undefined: port absent, no parity logic.

Decomposition:
- Package univ_shift_reg_pkg holds:
  - mode constants MODE_HOLD..MODE_ROR (3-bit);
  - sequencer state constants S_IDLE, S_SHIFT, S_FIN.
- One sub-module, usr_datapath: combinational next-q/next-sout given mode, q, d, sin. The top keeps the registers and FSM.

Test Plan:
- WIDTH=8: reset=1 with en=0 → q=0x00, busy=0, done=0 next edge; reset overrides LOAD of d=0xFF.
- LOAD d=0xA5, then mode ROL, start, count=8 → busy high 8 cycles, q returns 0xA5, done pulses once in cycle 9.
- q=0x81, SHR, sin=1, direct 3 enabled cycles → q=0xF0, sout=0; en=0 for 2 cycles → q held.
- q=0x01, SHL burst count=3, sin=0, en dropped for 2 cycles mid-burst → q=0x08, busy spans 5 cycles, single done.
- reset asserted in 2nd cycle of a count=5 burst → q=RST_VAL, busy=0, no done; a new start afterwards operates normally.
- With UNIV_SHIFT_REG_PARITY_EN: load 0x07 → parity=1 same cycle as q; load 0x03 → parity=0.
